reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//  General-purpose register file for the 5-stage MIPS core: 32 x 32-bit
//  registers, one synchronous write port (driven by the WB stage) and two
//  combinational read ports (rs/rt operand fetch in ID). Register 0 is
//  hardwired to zero. A write is bypassed to reads of the same register in
//  the same cycle, so WB->ID needs no extra forwarding.
// PARAMETERS
//  DATA_WIDTH  32  register width in bits
//  ADDR_WIDTH  5   register index width; depth = 2**ADDR_WIDTH (32)
// PORTS
//  clk       in   1           rising-edge clock
//  reset     in   1           synchronous, active-high reset
//  wr_num    in   ADDR_WIDTH  write register index
//  wr_data   in   DATA_WIDTH  write data
//  wr_en     in   1           write enable, sampled on posedge clk
//  rd0_num   in   ADDR_WIDTH  read port 0 index
//  rd0_data  out  DATA_WIDTH  read port 0 data (combinational)
//  rd1_num   in   ADDR_WIDTH  read port 1 index
//  rd1_data  out  DATA_WIDTH  read port 1 data (combinational)
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high.
//  - Reset: on a posedge clk with reset=1, all registers clear to 0 and
//    wr_en is ignored. rd0_data/rd1_data read 0 from the first reset edge on.
//  - Write: on a posedge clk with reset=0, wr_en=1 and wr_num!=0, the
//    register at wr_num takes wr_data. Writes to index 0 are discarded.
//  - Read: rdN_data = regs[rdN_num], combinational, zero-cycle latency.
//    rdN_num=0 always returns 0.
//  - Bypass: if reset=0, wr_en=1, wr_num!=0 and wr_num==rdN_num, then
//    rdN_data = wr_data in the same cycle, before the edge. The bypass
//    applies to each port independently. Both ports may read the same
//    index and then return identical data.
//  - No bypass while reset=1. Reset has priority over a simultaneous write.
//  - Priority: r0 rule > bypass > stored value.
//  - No X propagation: every register holds a defined value after reset.
//    No internal state machine. Data is stored verbatim, with no width
//    conversion.
// TESTING
//  - Reset: hold reset 1 cycle, then read all 32 indices on both ports ->
//    all return 0x00000000.
//  - Write/read: write r29=0x80120000 and r31=0x00000000, next cycle
//    rd0_num=29, rd1_num=31 -> rd0_data=0x80120000, rd1_data=0x00000000.
//  - r0 immutable: wr_en=1, wr_num=0, wr_data=0xDEADBEEF; read r0 during
//    and after the edge -> 0 on both ports.
//  - Bypass: r5=0x11111111 stored; in the same cycle drive wr_en=1,
//    wr_num=5, wr_data=0x22222222, rd0_num=5, rd1_num=6 -> rd0_data=
//    0x22222222 before the edge, rd1_data=old r6. After the edge r5 reads
//    0x22222222.
//  - wr_en=0: wr_num=7, wr_data=0xCAFEF00D, wr_en=0 -> r7 is unchanged and
//    rd0_data shows the stored value, not the bypass.
//  - Reset vs write: reset=1 with wr_en=1, wr_num=3, wr_data=0x12345678 ->
//    after the edge r3 reads 0. Mid-run reset clears previously written
//    r29.

Source files
------------

// File: rtl/reg_file.sv
// 32 x 32 MIPS register file: one synchronous write port, two combinational read
// ports, r0 hardwired to zero, same-cycle write-to-read bypass on each port.
module reg_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] wr_num,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] rd0_num,
   output logic [DATA_WIDTH-1:0] rd0_data,
   input  logic [ADDR_WIDTH-1:0] rd1_num,
   output logic [DATA_WIDTH-1:0] rd1_data
);
   localparam int DEPTH   = 2 ** ADDR_WIDTH;
   localparam int NUM_RD  = 2;

   logic [DEPTH-1:0][DATA_WIDTH-1:0]  regs_q, regs_d;
   logic [NUM_RD-1:0][ADDR_WIDTH-1:0] rd_num;
   logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data;
   logic                              wr_hit;

   // A write that will actually land; also the bypass qualifier for the read ports.
   assign wr_hit = !reset && wr_en && (wr_num != '0);

   always_comb begin
      regs_d = regs_q;
      if (wr_hit) regs_d[wr_num] = wr_data;
      regs_d[0] = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) regs_q <= '0;
      else       regs_q <= regs_d;
   end

   assign rd_num   = {rd1_num, rd0_num};
   assign rd0_data = rd_data[0];
   assign rd1_data = rd_data[1];

   // r0 rule > bypass > stored value, independently per port.
   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      assign rd_data[p] = (rd_num[p] == '0)                ? '0      :
                          (wr_hit && (wr_num == rd_num[p])) ? wr_data :
                                                              regs_q[rd_num[p]];
   end
endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset clear, write/read, r0, bypass, wr_en gating,
// and reset priority over a simultaneous write.
module tb_reg_file;
   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  wr_num, rd0_num, rd1_num;
   logic [31:0] wr_data, rd0_data, rd1_data;
   logic        wr_en;
   int          n_chk = 0;
   int          n_pass = 0;

   reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk(clk), .reset(reset),
      .wr_num(wr_num), .wr_data(wr_data), .wr_en(wr_en),
      .rd0_num(rd0_num), .rd0_data(rd0_data),
      .rd1_num(rd1_num), .rd1_data(rd1_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Advance past the next rising edge; inputs change and outputs settle off-edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] n, input logic [31:0] d);
      wr_en = 1'b1; wr_num = n; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b1; wr_num = 5'd3; wr_data = 32'h1234_5678;
      rd0_num = 5'd3; rd1_num = 5'd0;
      tick();
      #1;
      chk("rst_nobypass_rd0", rd0_data, 32'h0);
      reset = 1'b0; wr_en = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rd0_num = 5'(i); rd1_num = 5'(31 - i);
         #1;
         chk($sformatf("rst_rd0_r%0d", i), rd0_data, 32'h0);
         chk($sformatf("rst_rd1_r%0d", 31 - i), rd1_data, 32'h0);
      end

      wr(5'd31, 32'hFFFF_FFFF);
      wr(5'd29, 32'h8012_0000);
      wr(5'd31, 32'h0000_0000);
      rd0_num = 5'd29; rd1_num = 5'd31;
      #1;
      chk("wr_r29", rd0_data, 32'h8012_0000);
      chk("wr_r31", rd1_data, 32'h0000_0000);

      wr_en = 1'b1; wr_num = 5'd0; wr_data = 32'hDEAD_BEEF;
      rd0_num = 5'd0; rd1_num = 5'd0;
      #1;
      chk("r0_during_rd0", rd0_data, 32'h0);
      chk("r0_during_rd1", rd1_data, 32'h0);
      tick();
      wr_en = 1'b0;
      #1;
      chk("r0_after_rd0", rd0_data, 32'h0);
      chk("r0_after_rd1", rd1_data, 32'h0);

      wr(5'd5, 32'h1111_1111);
      wr(5'd6, 32'h6666_6666);
      wr_en = 1'b1; wr_num = 5'd5; wr_data = 32'h2222_2222;
      rd0_num = 5'd5; rd1_num = 5'd6;
      #1;
      chk("byp_rd0", rd0_data, 32'h2222_2222);
      chk("byp_rd1_old_r6", rd1_data, 32'h6666_6666);
      rd1_num = 5'd5;
      #1;
      chk("byp_both_rd1", rd1_data, 32'h2222_2222);
      tick();
      wr_en = 1'b0;
      #1;
      chk("byp_after_r5", rd0_data, 32'h2222_2222);

      wr(5'd7, 32'h7777_7777);
      wr_en = 1'b0; wr_num = 5'd7; wr_data = 32'hCAFE_F00D; rd0_num = 5'd7;
      #1;
      chk("wren0_before", rd0_data, 32'h7777_7777);
      tick();
      chk("wren0_after", rd0_data, 32'h7777_7777);

      wr(5'd3, 32'hA5A5_A5A5);
      reset = 1'b1; wr_en = 1'b1; wr_num = 5'd3; wr_data = 32'h1234_5678;
      rd0_num = 5'd29; rd1_num = 5'd3;
      #1;
      chk("rstw_pre_r29", rd0_data, 32'h8012_0000);
      chk("rstw_pre_r3_nobyp", rd1_data, 32'hA5A5_A5A5);
      tick();
      chk("rstw_post_r29", rd0_data, 32'h0);
      chk("rstw_post_r3", rd1_data, 32'h0);
      reset = 1'b0; wr_en = 1'b0;
      #1;
      chk("rstw_rel_r3", rd1_data, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
